adam_axil_reg_resp: RTL and testbench
=====================================

Name: adam_axil_reg_resp

Overview:
- AXI-Lite responder (subordinate endpoint) that terminates transactions issued by the LSDOM/HSDOM fabric master ports, such as syscfg or peripheral windows.
- Converts each AXI-Lite read or write into a single-beat request/grant access on a flat word-addressed register port, then returns OKAY or SLVERR.
- Supports the codebase pause protocol so the enclosing domain can quiesce it between transactions.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width
DATA_WIDTH, 32, AXI-Lite/register data width (32 or 64)
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width (derived)
NO_REGS, 16, number of words in the register window; must be ≥1
REG_IDX_WIDTH, $clog2(NO_REGS) min 1, register index width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
pause_req  in  1  pause request
pause_ack  out  1  pause acknowledge
slv  AXI_LITE.Slave  -  aw/w/b/ar/r channels, ADDR_WIDTH/DATA_WIDTH
reg_req  out  1  register access request, held until reg_gnt
reg_we  out  1  1=write, 0=read
reg_idx  out  REG_IDX_WIDTH  word index
reg_wdata  out  DATA_WIDTH  write data
reg_wstrb  out  STRB_WIDTH  write strobes
reg_gnt  in  1  access accepted; rdata/err valid in this cycle
reg_rdata  in  DATA_WIDTH  read data, sampled on reg_gnt
reg_err  in  1  access error, sampled on reg_gnt

Behaviour:
- Reset: all *_ready=0, bvalid=0, rvalid=0, reg_req=0, pause_ack=0, FSM=IDLE, AW/W holding registers empty, rr_last=WRITE.
- FSM states: IDLE, ACCESS, WR_RESP, RD_RESP, PAUSED.
- IDLE:
  - aw_ready=!aw_full && !pause_req; w_ready=!w_full. AW and W are latched independently, in any order or in the same cycle.
  - ar_ready=!pause_req && !(aw_full && w_full); AR latched in one cycle.
  - A write is eligible when aw_full && w_full; a read is eligible when AR is latched.
- Arbitration: at most one of write/read is taken at a time; if both are eligible, the type opposite to rr_last wins. rr_last updates on each taken access.
- Decode: idx = addr >> $clog2(STRB_WIDTH). If idx ≥ NO_REGS, go directly to the response state with SLVERR; no reg_req is issued.
- Unaligned addresses: low bits are ignored.
- A write with wstrb=0 still issues reg_req and returns OKAY.
- ACCESS: reg_req=1 with stable we/idx/wdata/wstrb until reg_gnt. On reg_gnt:
  - capture rdata and err;
  - resp = err ? SLVERR(2'b10) : OKAY;
  - go to WR_RESP or RD_RESP.
- WR_RESP: bvalid=1 holding bresp until bready, then clear aw_full/w_full and return to IDLE.
- RD_RESP: rvalid=1 holding rdata/rresp until rready, then return to IDLE.
- Error reads return rdata=0.
- Latency: with AR accepted in cycle t and reg_gnt tied high, reg_req is asserted in t+1, rvalid in t+2, and completion occurs in t+2 if rready=1. Write latency from the later of AW/W is identical.
- Throughput: one transaction in flight; no new AR is accepted until the response handshake completes.
- Pause:
  - While pause_req=1, no new AW or AR is accepted.
  - An in-flight access and its response always complete.
  - A latched AW without W keeps w_ready=1 until W arrives, then completes.
  - A latched W without AW keeps aw_ready=1 for that single AW.
  - Enter PAUSED only when IDLE and both holding registers are empty; pause_ack=1 from the next cycle.
  - When pause_req drops, pause_ack=0 on the following cycle, then return to IDLE.
- prot fields are ignored.
- rst mid-transaction drops all state immediately, including pending responses; this is not AXI-compliant, so the fabric is reset together with the block.

Decomposition:
- adam_cfg_pkg (shared): AXI resp encodings (RESP_OKAY, RESP_SLVERR), FSM state enum typedef.
- Sub-module adam_axil_reg_resp_hold: single-entry valid/ready holding register, instantiated for AW, W and AR; outputs full, data and ready.

Test Plan:
1. AW addr=0x8 and W data=0xDEADBEEF, strb=0xF, in the same cycle; reg_gnt=1 -> reg_req one cycle later with idx=2 and we=1; bvalid next cycle with bresp=OKAY.
2. W arrives 3 cycles before AW (addr=0x0) -> no reg_req until AW arrives; then a single write to idx=0 and exactly one B response.
3. AR addr=0x40 with NO_REGS=16 -> no reg_req; rvalid with rresp=SLVERR and rdata=0.
4. AR addr=0x4 with reg_gnt delayed 5 cycles, reg_rdata=0x1234, rready low for 2 cycles -> reg_req held stable for 6 cycles; rdata=0x1234 held until rready; reg_err=1 variant -> SLVERR.
5. Write and read eligible simultaneously, back-to-back with rr_last reset -> read served first, then write, then alternating order.
6. pause_req asserted while AW is latched without W -> ar_ready=0 and aw_ready=0, w_ready=1; W then B completes; pause_ack=1 one cycle later; pause_req=0 -> pause_ack=0 the next cycle and new AR accepted.

Source files
------------

// File: rtl/adam_cfg_pkg.sv
// Shared definitions for the AXI-Lite register responder: response codes,
// FSM state encoding and arbitration history.
package adam_cfg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WR_RESP,
    ST_RD_RESP,
    ST_PAUSED
  } state_e;

  typedef enum logic {
    RR_WRITE,
    RR_READ
  } rr_e;

  // Index width for a register window of n words; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adam_axil_reg_resp_hold.sv
// Single-entry valid/ready holding register. The _c outputs bypass the
// incoming beat so a transfer can be consumed in the cycle it is accepted.
module adam_axil_reg_resp_hold #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             take,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready_c,
  output logic             full,
  output logic             avail_c,
  output logic [WIDTH-1:0] data_c
);

  logic [WIDTH-1:0] data_q;
  logic             fire;

  assign in_ready_c = en && !full;
  assign fire       = in_valid && in_ready_c;
  assign avail_c    = full || fire;
  assign data_c     = full ? data_q : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      data_q <= '0;
    end else begin
      if (fire) begin
        data_q <= in_data;
      end
      if (take) begin
        full <= 1'b0;
      end else if (fire) begin
        full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/adam_axil_reg_resp.sv
// AXI-Lite subordinate that turns each read or write into one request/grant
// access on a flat word-indexed register port, with a quiesce handshake.
module adam_axil_reg_resp
  import adam_cfg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned NO_REGS       = 16,
  parameter int unsigned REG_IDX_WIDTH = idx_width(NO_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pause_req,
  output logic                     pause_ack,
  input  logic [ADDR_WIDTH-1:0]    aw_addr,
  input  logic                     aw_valid,
  output logic                     aw_ready,
  input  logic [DATA_WIDTH-1:0]    w_data,
  input  logic [STRB_WIDTH-1:0]    w_strb,
  input  logic                     w_valid,
  output logic                     w_ready,
  output logic [1:0]               b_resp,
  output logic                     b_valid,
  input  logic                     b_ready,
  input  logic [ADDR_WIDTH-1:0]    ar_addr,
  input  logic                     ar_valid,
  output logic                     ar_ready,
  output logic [DATA_WIDTH-1:0]    r_data,
  output logic [1:0]               r_resp,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic                     reg_req,
  output logic                     reg_we,
  output logic [REG_IDX_WIDTH-1:0] reg_idx,
  output logic [DATA_WIDTH-1:0]    reg_wdata,
  output logic [STRB_WIDTH-1:0]    reg_wstrb,
  input  logic                     reg_gnt,
  input  logic [DATA_WIDTH-1:0]    reg_rdata,
  input  logic                     reg_err
);

  localparam int unsigned OFFS_W = $clog2(STRB_WIDTH);
  localparam int unsigned WPAY_W = DATA_WIDTH + STRB_WIDTH;

  state_e state;
  rr_e    rr_last;

  logic                  idle;
  logic                  aw_en, w_en, ar_en;
  logic                  aw_full, w_full, ar_full;
  logic                  aw_avail, w_avail, ar_avail;
  logic [ADDR_WIDTH-1:0] aw_addr_c, ar_addr_c;
  logic [WPAY_W-1:0]     w_pay_c;
  logic [DATA_WIDTH-1:0] w_data_c;
  logic [STRB_WIDTH-1:0] w_strb_c;
  logic                  wr_elig, rd_elig;
  logic                  take_wr, take_rd;
  logic [ADDR_WIDTH-1:0] addr_sel, word;
  logic                  out_of_range;
  logic [1:0]            acc_resp;

  // Reset holds every ready low; pause only blocks the start of new transactions,
  // so a half-received write may still collect its missing channel.
  assign idle  = (state == ST_IDLE) && !rst;
  assign aw_en = idle && (!pause_req || w_full);
  assign w_en  = idle && (!pause_req || aw_full);
  assign ar_en = idle && !pause_req && !(aw_full && w_full);

  adam_axil_reg_resp_hold #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk        (clk),
    .rst        (rst),
    .en         (aw_en),
    .take       (take_wr),
    .in_valid   (aw_valid),
    .in_data    (aw_addr),
    .in_ready_c (aw_ready),
    .full       (aw_full),
    .avail_c    (aw_avail),
    .data_c     (aw_addr_c)
  );

  adam_axil_reg_resp_hold #(.WIDTH(WPAY_W)) u_w_hold (
    .clk        (clk),
    .rst        (rst),
    .en         (w_en),
    .take       (take_wr),
    .in_valid   (w_valid),
    .in_data    ({w_strb, w_data}),
    .in_ready_c (w_ready),
    .full       (w_full),
    .avail_c    (w_avail),
    .data_c     (w_pay_c)
  );

  adam_axil_reg_resp_hold #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
    .clk        (clk),
    .rst        (rst),
    .en         (ar_en),
    .take       (take_rd),
    .in_valid   (ar_valid),
    .in_data    (ar_addr),
    .in_ready_c (ar_ready),
    .full       (ar_full),
    .avail_c    (ar_avail),
    .data_c     (ar_addr_c)
  );

  assign {w_strb_c, w_data_c} = w_pay_c;

  // Round-robin: when both are ready the type not served last goes first.
  assign wr_elig = aw_avail && w_avail;
  assign rd_elig = ar_avail;
  assign take_rd = idle && rd_elig && (!wr_elig || (rr_last == RR_WRITE));
  assign take_wr = idle && wr_elig && !take_rd;

  assign addr_sel     = take_rd ? ar_addr_c : aw_addr_c;
  assign word         = addr_sel >> OFFS_W;
  assign out_of_range = word >= ADDR_WIDTH'(NO_REGS);
  assign acc_resp     = reg_err ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_last   <= RR_WRITE;
      pause_ack <= 1'b0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_idx   <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      b_valid   <= 1'b0;
      b_resp    <= RESP_OKAY;
      r_valid   <= 1'b0;
      r_resp    <= RESP_OKAY;
      r_data    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (take_rd || take_wr) begin
            rr_last   <= take_rd ? RR_READ : RR_WRITE;
            reg_we    <= take_wr;
            reg_idx   <= REG_IDX_WIDTH'(word);
            reg_wdata <= take_wr ? w_data_c : '0;
            reg_wstrb <= take_wr ? w_strb_c : '0;
            if (!out_of_range) begin
              reg_req <= 1'b1;
              state   <= ST_ACCESS;
            end else if (take_wr) begin
              b_valid <= 1'b1;
              b_resp  <= RESP_SLVERR;
              state   <= ST_WR_RESP;
            end else begin
              r_valid <= 1'b1;
              r_resp  <= RESP_SLVERR;
              r_data  <= '0;
              state   <= ST_RD_RESP;
            end
          end else if (pause_req && !aw_full && !w_full && !ar_full) begin
            pause_ack <= 1'b1;
            state     <= ST_PAUSED;
          end
        end
        ST_ACCESS: begin
          if (reg_gnt) begin
            reg_req <= 1'b0;
            if (reg_we) begin
              b_valid <= 1'b1;
              b_resp  <= acc_resp;
              state   <= ST_WR_RESP;
            end else begin
              r_valid <= 1'b1;
              r_resp  <= acc_resp;
              r_data  <= reg_err ? '0 : reg_rdata;
              state   <= ST_RD_RESP;
            end
          end
        end
        ST_WR_RESP: begin
          if (b_ready) begin
            b_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_RD_RESP: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_PAUSED: begin
          if (!pause_req) begin
            pause_ack <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adam_axil_reg_resp.sv
// Scoreboard bench for adam_axil_reg_resp: stimulus pushes expected register
// accesses and responses, a forked monitor pops them on each handshake.
module tb_adam_axil_reg_resp;

  typedef struct {
    logic        we;
    logic [3:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  logic        clk, rst, pause_req, pause_ack;
  logic [31:0] aw_addr, w_data, ar_addr, r_data, reg_wdata, reg_rdata;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]  w_strb, reg_wstrb, reg_idx;
  logic [1:0]  b_resp, r_resp;
  logic        reg_req, reg_we, reg_gnt, reg_err;

  acc_t        exp_acc[$];
  logic [1:0]  exp_b[$];
  rsp_t        exp_r[$];

  int          checks, errors, req_cycles, gnt_delay, gnt_cnt;
  logic [31:0] rd_value;
  logic        rd_err;

  adam_axil_reg_resp dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_gnt(reg_gnt),
    .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=0x%0h expected=none", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register-side responder: grant after gnt_delay waiting cycles.
  task automatic responder();
    forever begin
      @(posedge clk);
      #1;
      reg_rdata = rd_value;
      reg_err   = rd_err;
      if (reg_req) begin
        reg_gnt = (gnt_cnt == gnt_delay);
        gnt_cnt++;
      end else begin
        reg_gnt = 1'b0;
        gnt_cnt = 0;
      end
    end
  endtask

  task automatic monitor();
    acc_t        a;
    rsp_t        r;
    logic [1:0]  b;
    logic        pend;
    logic [40:0] snap;
    pend = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (reg_req) req_cycles++;
      if (reg_req && pend)
        chk("acc_stable", 64'({reg_we, reg_idx, reg_wdata, reg_wstrb}), 64'(snap));
      pend = reg_req && !reg_gnt;
      snap = {reg_we, reg_idx, reg_wdata, reg_wstrb};
      if (reg_req && reg_gnt) begin
        if (exp_acc.size() == 0) fail_now("acc_unexpected", 64'(reg_idx));
        else begin
          a = exp_acc.pop_front();
          chk("acc_we", 64'(reg_we), 64'(a.we));
          chk("acc_idx", 64'(reg_idx), 64'(a.idx));
          if (a.we) begin
            chk("acc_wdata", 64'(reg_wdata), 64'(a.wdata));
            chk("acc_wstrb", 64'(reg_wstrb), 64'(a.wstrb));
          end
        end
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected", 64'(b_resp));
        else begin
          b = exp_b.pop_front();
          chk("b_resp", 64'(b_resp), 64'(b));
        end
      end
      if (r_valid && r_ready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected", 64'(r_data));
        else begin
          r = exp_r.pop_front();
          chk("r_data", 64'(r_data), 64'(r.data));
          chk("r_resp", 64'(r_resp), 64'(r.resp));
        end
      end
    end
  endtask

  // Drive any subset of AW/W/AR together and drop each valid once accepted.
  task automatic send(input logic do_aw, input logic do_w, input logic do_ar,
                      input logic [31:0] aaddr, input logic [31:0] wdat,
                      input logic [3:0] strb, input logic [31:0] raddr);
    logic aw_hs, w_hs, ar_hs;
    aw_valid = do_aw; aw_addr = aaddr;
    w_valid  = do_w;  w_data  = wdat; w_strb = strb;
    ar_valid = do_ar; ar_addr = raddr;
    for (int i = 0; i < 50 && (aw_valid || w_valid || ar_valid); i++) begin
      @(negedge clk);
      aw_hs = aw_valid && aw_ready;
      w_hs  = w_valid && w_ready;
      ar_hs = ar_valid && ar_ready;
      tick();
      if (aw_hs) aw_valid = 1'b0;
      if (w_hs)  w_valid  = 1'b0;
      if (ar_hs) ar_valid = 1'b0;
    end
    if (aw_valid || w_valid || ar_valid) begin
      fail_now("send_timeout", 64'({aw_valid, w_valid, ar_valid}));
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (exp_acc.size() + exp_b.size() + exp_r.size()) != 0; i++)
      tick();
    if ((exp_acc.size() + exp_b.size() + exp_r.size()) != 0)
      fail_now("drain_timeout", 64'(exp_acc.size() + exp_b.size() + exp_r.size()));
    tick();
  endtask

  initial begin
    int rc;
    clk = 0; rst = 1; pause_req = 0;
    aw_addr = '0; aw_valid = 0; w_data = '0; w_strb = '0; w_valid = 0;
    ar_addr = '0; ar_valid = 0; b_ready = 1; r_ready = 1;
    reg_gnt = 0; reg_rdata = '0; reg_err = 0;
    checks = 0; errors = 0; req_cycles = 0; gnt_delay = 0; gnt_cnt = 0;
    rd_value = 32'h0; rd_err = 0;
    fork
      responder();
      monitor();
      begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_readies", 64'({aw_ready, w_ready, ar_ready}), 64'(0));
    chk("rst_valids", 64'({b_valid, r_valid, reg_req, pause_ack}), 64'(0));
    tick();
    rst = 0;
    tick();

    // 1: AW+W together, grant tied high
    exp_acc.push_back('{1'b1, 4'd2, 32'hDEADBEEF, 4'hF});
    exp_b.push_back(2'b00);
    aw_valid = 1; aw_addr = 32'h8; w_valid = 1; w_data = 32'hDEADBEEF; w_strb = 4'hF;
    @(negedge clk);
    chk("t1_ready", 64'({aw_ready, w_ready}), 64'(2'b11));
    tick();
    aw_valid = 0; w_valid = 0;
    @(negedge clk);
    chk("t1_req", 64'({reg_req, reg_we, reg_idx}), 64'({1'b1, 1'b1, 4'd2}));
    chk("t1_no_b_yet", 64'(b_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("t1_b", 64'({b_valid, b_resp}), 64'({1'b1, 2'b00}));
    wait_drain();

    // 2: W three cycles ahead of AW
    send(0, 1, 0, 32'h0, 32'h11223344, 4'h3, 32'h0);
    rc = req_cycles;
    repeat (3) tick();
    chk("t2_no_req", 64'(req_cycles - rc), 64'(0));
    exp_acc.push_back('{1'b1, 4'd0, 32'h11223344, 4'h3});
    exp_b.push_back(2'b00);
    send(1, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    wait_drain();

    // 3: out-of-range read and write, zero-strobe write, unaligned last word
    rc = req_cycles;
    exp_r.push_back('{32'h0, 2'b10});
    send(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h40);
    wait_drain();
    exp_b.push_back(2'b10);
    send(1, 1, 0, 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0);
    wait_drain();
    chk("t3_oor_no_req", 64'(req_cycles - rc), 64'(0));
    exp_acc.push_back('{1'b1, 4'd15, 32'h0000_00AA, 4'h0});
    exp_b.push_back(2'b00);
    send(1, 1, 0, 32'h3C, 32'h0000_00AA, 4'h0, 32'h0);
    wait_drain();
    rd_value = 32'h0F0F_000F;
    exp_acc.push_back('{1'b0, 4'd15, 32'h0, 4'h0});
    exp_r.push_back('{32'h0F0F_000F, 2'b00});
    send(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h3F);
    wait_drain();

    // 4: delayed grant, back-pressured R, then an error read
    gnt_delay = 5; rd_value = 32'h1234; r_ready = 0;
    exp_acc.push_back('{1'b0, 4'd1, 32'h0, 4'h0});
    exp_r.push_back('{32'h1234, 2'b00});
    rc = req_cycles;
    send(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h4);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (r_valid) break;
      tick();
    end
    chk("t4_req_cycles", 64'(req_cycles - rc), 64'(6));
    chk("t4_hold0", 64'({r_valid, r_data}), 64'({1'b1, 32'h1234}));
    tick();
    @(negedge clk);
    chk("t4_hold1", 64'({r_valid, r_data}), 64'({1'b1, 32'h1234}));
    tick();
    r_ready = 1;
    wait_drain();
    gnt_delay = 0; rd_err = 1;
    exp_acc.push_back('{1'b0, 4'd3, 32'h0, 4'h0});
    exp_r.push_back('{32'h0, 2'b10});
    send(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'hC);
    wait_drain();
    rd_err = 0;

    // 5: arbitration after a fresh reset
    rst = 1;
    repeat (2) tick();
    rst = 0;
    rd_value = 32'hCAFE_0005;
    exp_acc.push_back('{1'b0, 4'd5, 32'h0, 4'h0});
    exp_acc.push_back('{1'b1, 4'd4, 32'hA5A5_0001, 4'hF});
    exp_r.push_back('{32'hCAFE_0005, 2'b00});
    exp_b.push_back(2'b00);
    send(1, 1, 1, 32'h10, 32'hA5A5_0001, 4'hF, 32'h14);
    @(negedge clk);
    chk("t5_read_first", 64'({reg_req, reg_we, reg_idx}), 64'({1'b1, 1'b0, 4'd5}));
    wait_drain();
    rd_value = 32'h0BAD_0008;
    exp_acc.push_back('{1'b0, 4'd8, 32'h0, 4'h0});
    exp_r.push_back('{32'h0BAD_0008, 2'b00});
    send(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h20);
    wait_drain();
    rd_value = 32'h0A0A_000A;
    exp_acc.push_back('{1'b1, 4'd9, 32'h1234_5678, 4'hC});
    exp_acc.push_back('{1'b0, 4'd10, 32'h0, 4'h0});
    exp_b.push_back(2'b00);
    exp_r.push_back('{32'h0A0A_000A, 2'b00});
    send(1, 1, 1, 32'h24, 32'h1234_5678, 4'hC, 32'h28);
    @(negedge clk);
    chk("t5_write_first", 64'({reg_req, reg_we, reg_idx}), 64'({1'b1, 1'b1, 4'd9}));
    wait_drain();

    // 6: pause with a half-received write
    rd_value = 32'h7777_0007;
    exp_acc.push_back('{1'b1, 4'd6, 32'h55AA_55AA, 4'hF});
    exp_acc.push_back('{1'b0, 4'd7, 32'h0, 4'h0});
    exp_b.push_back(2'b00);
    exp_r.push_back('{32'h7777_0007, 2'b00});
    send(1, 0, 0, 32'h18, 32'h0, 4'h0, 32'h0);
    pause_req = 1; ar_valid = 1; ar_addr = 32'h1C;
    @(negedge clk);
    chk("t6_readies", 64'({aw_ready, w_ready, ar_ready}), 64'(3'b010));
    tick();
    w_valid = 1; w_data = 32'h55AA_55AA; w_strb = 4'hF;
    @(negedge clk);
    chk("t6_w_ready", 64'({w_ready, ar_ready}), 64'(2'b10));
    tick();
    w_valid = 0;
    @(negedge clk);
    chk("t6_req", 64'({reg_req, reg_we, reg_idx}), 64'({1'b1, 1'b1, 4'd6}));
    tick();
    @(negedge clk);
    chk("t6_b", 64'({b_valid, b_resp}), 64'({1'b1, 2'b00}));
    tick();
    @(negedge clk);
    chk("t6_ack_low", 64'({pause_ack, ar_ready}), 64'(0));
    tick();
    @(negedge clk);
    chk("t6_ack_high", 64'(pause_ack), 64'(1));
    tick();
    @(negedge clk);
    chk("t6_paused_ar", 64'({pause_ack, ar_ready, reg_req}), 64'(3'b100));
    tick();
    pause_req = 0;
    @(negedge clk);
    chk("t6_ack_hold", 64'(pause_ack), 64'(1));
    tick();
    @(negedge clk);
    chk("t6_resume", 64'({pause_ack, ar_ready}), 64'(2'b01));
    tick();
    ar_valid = 0;
    wait_drain();

    chk("end_queues", 64'(exp_acc.size() + exp_b.size() + exp_r.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
